rotor_step_ctrl: RTL

- Sequences the three-rotor forward path (rotor0 → rotor1 → rotor2) one character at a time.
- Owns the registered rotor positions and applies Enigma-style stepping before each character is encrypted.
- Drives the character and the three positions into the combinational path, waits a settle window, then registers the path result.
- Presents the result on a ready/valid output handshake.

---
 rtl/rotor_step_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/rotor_step_ctrl.sv
// Three-rotor stepping controller: owns rotor positions, drives the forward path, captures its result.
// Optional historical double-step behaviour is enabled by defining ROTOR_DOUBLE_STEP_EN.
module rotor_step_ctrl #(
  parameter int ALPHABET      = 26,
  parameter int R0_NOTCH      = 16,
  parameter int R1_NOTCH      = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_en,
  input  logic [5:0]  load_r0,
  input  logic [5:0]  load_r1,
  input  logic [5:0]  load_r2,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_char,
  output logic [5:0]  path_in,
  output logic [5:0]  r0_pos,
  output logic [5:0]  r1_pos,
  output logic [5:0]  r2_pos,
  input  logic [5:0]  path_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_char,
  output logic [15:0] char_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [5:0]  r_r0;
  logic [5:0]  r_r1;
  logic [5:0]  r_r2;
  logic [5:0]  r_path_in;
  logic [5:0]  r_out_char;
  logic        r_out_valid;
  logic        r_in_ready;
  logic [15:0] r_char_count;
  logic [3:0]  r_settle;

  logic        w_accept;
  logic        w_load;
  logic        w_capture;
  logic        w_r0_hit;
  logic        w_r1_hit;
  logic        w_step_r1;
  logic        w_step_r2;

  function automatic logic [5:0] inc_mod(input logic [5:0] v);
    return (v == 6'(ALPHABET - 1)) ? 6'd0 : v + 6'd1;
  endfunction

  // Out-of-range load values collapse to position zero
  function automatic logic [5:0] legalise(input logic [5:0] v);
    return ({1'b0, v} >= 7'(ALPHABET)) ? 6'd0 : v;
  endfunction

  assign w_accept  = (r_state == S_IDLE) && in_valid && !load_en;
  assign w_load    = (r_state == S_IDLE) && load_en;
  assign w_capture = (r_state == S_EVAL) && (r_settle == 4'd0);
  assign w_r0_hit  = (r_r0 == 6'(R0_NOTCH));
  assign w_r1_hit  = (r_r1 == 6'(R1_NOTCH));

`ifdef ROTOR_DOUBLE_STEP_EN
  assign w_step_r1 = w_r0_hit | w_r1_hit;
  assign w_step_r2 = w_r1_hit;
`else
  assign w_step_r1 = w_r0_hit;
  assign w_step_r2 = w_r0_hit & w_r1_hit;
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_EVAL;
        else          w_next_state = S_IDLE;
      end
      S_EVAL: begin
        if (w_capture) w_next_state = S_OUT;
        else           w_next_state = S_EVAL;
      end
      S_OUT: begin
        if (out_ready) w_next_state = S_IDLE;
        else           w_next_state = S_OUT;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state == S_IDLE);
    end
  end

  // Positions move only on a load or an accepted character; everything else holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r0         <= 6'd0;
      r_r1         <= 6'd0;
      r_r2         <= 6'd0;
      r_path_in    <= 6'd0;
      r_out_char   <= 6'd0;
      r_out_valid  <= 1'b0;
      r_char_count <= 16'd0;
      r_settle     <= 4'd0;
    end else if (w_load) begin
      r_r0         <= legalise(load_r0);
      r_r1         <= legalise(load_r1);
      r_r2         <= legalise(load_r2);
      r_char_count <= 16'd0;
    end else if (w_accept) begin
      r_path_in <= in_char;
      r_r0      <= inc_mod(r_r0);
      r_r1      <= w_step_r1 ? inc_mod(r_r1) : r_r1;
      r_r2      <= w_step_r2 ? inc_mod(r_r2) : r_r2;
      r_settle  <= 4'(SETTLE_CYCLES - 1);
    end else if (w_capture) begin
      r_out_char   <= path_out;
      r_out_valid  <= 1'b1;
      r_char_count <= r_char_count + 16'd1;
    end else if (r_state == S_EVAL) begin
      r_settle <= r_settle - 4'd1;
    end else if ((r_state == S_OUT) && out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign in_ready   = r_in_ready;
  assign path_in    = r_path_in;
  assign r0_pos     = r_r0;
  assign r1_pos     = r_r1;
  assign r2_pos     = r_r2;
  assign out_valid  = r_out_valid;
  assign out_char   = r_out_char;
  assign char_count = r_char_count;

endmodule
